// File: rtl/mem_arbiter.sv
// Two-to-one round-robin arbiter that shares one memory port between instruction fetch (m0)
// and data (m1). An in-order tag FIFO sends each response back to the port that issued it.
module mem_arbiter #(
  parameter int unsigned Xlen     = 32,
  parameter int unsigned MaskBits = 4,
  parameter int unsigned Depth    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_valid_i,
  output logic                m0_ready_o,
  input  logic [Xlen-1:0]     m0_addr_i,
  input  logic [Xlen-1:0]     m0_wdata_i,
  input  logic [MaskBits-1:0] m0_wmask_i,
  output logic [Xlen-1:0]     m0_rdata_o,
  output logic                m0_rvalid_o,
  input  logic                m1_valid_i,
  output logic                m1_ready_o,
  input  logic [Xlen-1:0]     m1_addr_i,
  input  logic [Xlen-1:0]     m1_wdata_i,
  input  logic [MaskBits-1:0] m1_wmask_i,
  output logic [Xlen-1:0]     m1_rdata_o,
  output logic                m1_rvalid_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i,
  output logic                resp_err_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Depth-1:0] r_tags;
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             r_last_grant;
  logic             r_lock;
  logic             r_lock_id;
  logic             r_resp_err;

  logic w_grant;
  logic w_gnt_valid;
  logic w_space;
  logic w_accept;
  logic w_pop;
  logic w_stray;
  logic w_head;

  // A held grant wins over round-robin so the stalled requester's fields stay on the bus.
  always_comb begin
    w_grant = 1'b0;
    if (r_lock) begin
      w_grant = r_lock_id;
    end else if (m0_valid_i && m1_valid_i) begin
      w_grant = ~r_last_grant;
    end else if (m1_valid_i) begin
      w_grant = 1'b1;
    end
  end

  assign w_gnt_valid = w_grant ? m1_valid_i : m0_valid_i;
  // A full FIFO can still accept when the head is popped in the same cycle.
  assign w_space     = (r_count < DepthC) || ((r_count == DepthC) && mem_rvalid_i);

  assign mem_valid_o = ~rst_i & w_gnt_valid & w_space;
  assign m0_ready_o  = ~rst_i & mem_ready_i & w_space & ~w_grant;
  assign m1_ready_o  = ~rst_i & mem_ready_i & w_space & w_grant;
  assign w_accept    = mem_valid_o & mem_ready_i;

  assign mem_addr_o  = w_grant ? m1_addr_i  : m0_addr_i;
  assign mem_wdata_o = w_grant ? m1_wdata_i : m0_wdata_i;
  assign mem_wmask_o = w_grant ? m1_wmask_i : m0_wmask_i;

  assign w_pop   = mem_rvalid_i & (r_count != '0);
  assign w_stray = mem_rvalid_i & (r_count == '0);
  assign w_head  = r_tags[r_rptr];

  assign m0_rvalid_o = ~rst_i & w_pop & ~w_head;
  assign m1_rvalid_o = ~rst_i & w_pop & w_head;
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;
  assign resp_err_o  = r_resp_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tags       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b0;
      r_lock       <= 1'b0;
      r_lock_id    <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tags[r_wptr] <= w_grant;
        r_wptr         <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_lock       <= 1'b0;
      end else if (w_gnt_valid) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end
      if (w_stray) begin
        r_resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model (outstanding-owner queue, last winner, held grant, sticky error).
module tb_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int MB    = 4;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m0_valid, m1_valid, m0_ready, m1_ready;
  logic [XLEN-1:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [MB-1:0]   m0_wmask, m1_wmask;
  logic            m0_rvalid, m1_rvalid;
  logic            mem_valid, mem_ready, mem_rvalid, resp_err;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [MB-1:0]   mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.Xlen(XLEN), .MaskBits(MB), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_wmask_i(m0_wmask), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_wmask_i(m1_wmask), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .resp_err_o(resp_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int owners[$];
  bit last_win;
  bit held;
  bit held_id;
  bit err_m;

  int acc_log[$];
  int rv_log[$];
  logic [XLEN-1:0] last_rd0;
  bit exp_acc0, exp_acc1;
  logic obs_r0, obs_r1, obs_mv;
  bit pend0, pend1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(string tag, input int q[$], input int n, input logic [31:0] pat);
    logic [31:0] bits = '0;
    chk({tag, "_len"}, q.size(), n);
    foreach (q[i]) if (i < 32 && q[i] != 0) bits[i] = 1'b1;
    chk(tag, bits, pat);
  endtask

  task automatic set_idle();
    m0_valid = 0; m1_valid = 0; mem_ready = 0; mem_rvalid = 0;
    m0_wmask = '0; m1_wmask = '0;
  endtask

  task automatic do_reset();
    rst = 1; m0_valid = 1; m1_valid = 1; mem_ready = 1; mem_rvalid = 1;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    @(posedge clk);
    #1;
    rst = 0;
    set_idle();
    owners.delete(); last_win = 0; held = 0; held_id = 0; err_m = 0;
    acc_log.delete(); rv_log.delete(); pend0 = 0; pend1 = 0;
  endtask

  // Inputs were set right after a rising edge; check mid-cycle, then advance the model.
  task automatic tick();
    bit gnt, gv, space, mv, r0, r1, pop, hid, stray;
    #4;
    if (held) gnt = held_id;
    else if (m0_valid && m1_valid) gnt = !last_win;
    else gnt = m1_valid;
    gv    = gnt ? m1_valid : m0_valid;
    space = (owners.size() < DEPTH) || (owners.size() == DEPTH && mem_rvalid);
    mv    = gv && space;
    r0    = mem_ready && space && !gnt;
    r1    = mem_ready && space && gnt;
    pop   = mem_rvalid && owners.size() > 0;
    stray = mem_rvalid && owners.size() == 0;
    hid   = 0;
    if (pop) hid = (owners[0] == 1);

    chk("mem_valid", mem_valid, mv);
    chk("m0_ready", m0_ready, r0);
    chk("m1_ready", m1_ready, r1);
    chk("m0_rvalid", m0_rvalid, pop && !hid);
    chk("m1_rvalid", m1_rvalid, pop && hid);
    chk("m0_rdata", m0_rdata, mem_rdata);
    chk("m1_rdata", m1_rdata, mem_rdata);
    chk("resp_err", resp_err, err_m);
    if (gv) begin
      chk("mem_addr", mem_addr, gnt ? m1_addr : m0_addr);
      chk("mem_wdata", mem_wdata, gnt ? m1_wdata : m0_wdata);
      chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, gnt ? m1_wmask : m0_wmask});
    end

    obs_r0 = m0_ready; obs_r1 = m1_ready; obs_mv = mem_valid;
    if (m0_valid && m0_ready) acc_log.push_back(0);
    if (m1_valid && m1_ready) acc_log.push_back(1);
    if (m0_rvalid) begin rv_log.push_back(0); last_rd0 = m0_rdata; end
    if (m1_rvalid) rv_log.push_back(1);
    exp_acc0 = m0_valid && r0;
    exp_acc1 = m1_valid && r1;

    @(posedge clk);
    if (pop) void'(owners.pop_front());
    if (mv && mem_ready) begin
      owners.push_back(gnt); last_win = gnt; held = 0;
    end else if (gv) begin
      held = 1; held_id = gnt;
    end
    if (stray) err_m = 1;
    #1;
  endtask

  initial begin
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; mem_rdata = '0;
    set_idle();
    do_reset();
    chk("reset_err", resp_err, 0);

    // Single-port read, answered two cycles after acceptance
    m0_valid = 1; m0_addr = 32'h100; mem_ready = 1; tick();
    set_idle(); tick();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; tick();
    set_idle(); tick();
    chk_seq("read_rv", rv_log, 1, 32'h0);
    chk("read_data", last_rd0, 32'hDEADBEEF);
    acc_log.delete(); rv_log.delete();

    // Tie-breaking: last winner is m0, so m1 goes first
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h10; m1_addr = 32'h20; mem_ready = 1; tick();
    mem_rvalid = 1; mem_rdata = 32'h1111; tick(); tick(); tick();
    set_idle(); mem_rvalid = 1; tick();
    set_idle();
    chk_seq("tie_acc", acc_log, 4, 32'b0101);
    chk_seq("tie_rv", rv_log, 4, 32'b0101);
    acc_log.delete(); rv_log.delete();

    // Backpressure: m0 stalls, m1 arrives, grant must stay on m0
    m0_valid = 1; m0_addr = 32'h300; m0_wdata = 32'hAA; mem_ready = 0; tick();
    m1_valid = 1; m1_addr = 32'h400; m1_wdata = 32'hBB; tick(); tick();
    mem_ready = 1; tick();
    m0_valid = 0; tick();
    set_idle(); mem_rvalid = 1; tick(); tick();
    set_idle();
    chk_seq("lock_acc", acc_log, 2, 32'b10);
    chk_seq("lock_rv", rv_log, 2, 32'b10);
    acc_log.delete(); rv_log.delete();

    // Full FIFO: third request blocked until a response frees a slot the same cycle
    m0_valid = 1; m0_addr = 32'h500; mem_ready = 1; tick();
    m0_addr = 32'h504; tick();
    m0_addr = 32'h508; tick();
    chk("full_ready0", obs_r0, 0);
    chk("full_mem_valid", obs_mv, 0);
    mem_rvalid = 1; tick();
    chk("full_bypass_ready0", obs_r0, 1);
    m0_valid = 0; m1_valid = 1; m1_addr = 32'h600; mem_rvalid = 0; tick();
    chk("full_still_ready1", obs_r1, 0);
    mem_rvalid = 1; tick();
    m1_valid = 0; tick(); tick();
    set_idle();
    chk_seq("full_acc", acc_log, 4, 32'b1000);
    chk_seq("full_rv", rv_log, 4, 32'b1000);
    acc_log.delete(); rv_log.delete();

    // Write tagging: m1 write then m0 read
    m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'hCAFE; m1_wmask = 4'hF; mem_ready = 1; tick();
    m1_valid = 0; m0_valid = 1; m0_addr = 32'h104; m0_wmask = 4'h0; tick();
    set_idle(); mem_rvalid = 1; tick(); tick();
    set_idle();
    chk_seq("write_rv", rv_log, 2, 32'b01);
    acc_log.delete(); rv_log.delete();

    // Unexpected response, then reset with a request outstanding
    mem_rvalid = 1; tick();
    set_idle();
    chk("err_set", resp_err, 1);
    chk("err_no_rvalid", rv_log.size(), 0);
    tick();
    m0_valid = 1; m0_addr = 32'h700; mem_ready = 1; tick();
    set_idle();
    do_reset();
    chk("err_cleared", resp_err, 0);
    mem_rvalid = 1; tick();
    set_idle();
    chk("stale_resp_err", resp_err, 1);
    chk("stale_no_rvalid", rv_log.size(), 0);
    do_reset();
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h800; m1_addr = 32'h900; mem_ready = 1; tick();
    set_idle();
    chk_seq("post_reset_tie", acc_log, 1, 32'b1);
    do_reset();

    // Random traffic; requesters hold their request until accepted
    for (int n = 0; n < 500; n++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1; m0_addr = $urandom; m0_wdata = $urandom;
        m0_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1; m1_addr = $urandom; m1_wdata = $urandom;
        m1_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      m0_valid   = pend0;
      m1_valid   = pend1;
      mem_ready  = ($urandom_range(0, 3) != 0);
      mem_rvalid = (owners.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      mem_rdata  = $urandom;
      tick();
      if (exp_acc0) pend0 = 0;
      if (exp_acc1) pend1 = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
